// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU with registered single-cycle ops and iterative MULT/DIV.
// Define SEQ_ALU_FLAGS_EN to add the registered {DZ,V,C,N,Z} flags output.

`ifndef ADD
`define ADD  16'h0001
`define SUB  16'h0002
`define MULT 16'h0004
`define DIV  16'h0008
`define INC  16'h0010
`define DEC  16'h0020
`define AND  16'h0040
`define OR   16'h0080
`define XOR  16'h0100
`endif

module seq_alu #(
    parameter int WIDTH   = 16,
    parameter int OP_BITS = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OP_BITS-1:0] op_code,
    input  logic [WIDTH-1:0]   data_A,
    input  logic [WIDTH-1:0]   data_B,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic [WIDTH-1:0]   result_hi
`ifdef SEQ_ALU_FLAGS_EN
    ,
    output logic [4:0]         flags
`endif
);

    localparam int MSB = WIDTH - 1;
    localparam int CW  = $clog2(WIDTH);

    localparam logic [OP_BITS-1:0] OP_ADD  = OP_BITS'(`ADD);
    localparam logic [OP_BITS-1:0] OP_SUB  = OP_BITS'(`SUB);
    localparam logic [OP_BITS-1:0] OP_MULT = OP_BITS'(`MULT);
    localparam logic [OP_BITS-1:0] OP_DIV  = OP_BITS'(`DIV);
    localparam logic [OP_BITS-1:0] OP_INC  = OP_BITS'(`INC);
    localparam logic [OP_BITS-1:0] OP_DEC  = OP_BITS'(`DEC);
    localparam logic [OP_BITS-1:0] OP_AND  = OP_BITS'(`AND);
    localparam logic [OP_BITS-1:0] OP_OR   = OP_BITS'(`OR);
    localparam logic [OP_BITS-1:0] OP_XOR  = OP_BITS'(`XOR);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] rhi_q, rhi_d;
    logic [WIDTH-1:0] sc_res;
    logic [WIDTH:0]   mac;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   tdiff;
    logic             ge;
    logic             accept;
    logic             start_mul;
    logic             start_div;
    logic             div_zero;

    assign in_ready = rst_n
                    && (state_q == IDLE
                    || (state_q == DONE && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign result    = res_q;
    assign result_hi = rhi_q;

    assign start_mul = (op_code == OP_MULT);
    assign start_div = (op_code == OP_DIV) && (data_A != '0);
    assign div_zero  = (op_code == OP_DIV) && (data_A == '0);

    // Shift-add step: {hi,lo} holds partial product over remaining multiplier bits
    assign mac = {1'b0, hi_q}
               + (lo_q[0] ? {1'b0, a_q} : '0);

    // Restoring step: hi is the partial remainder, lo shifts quotient bits in
    assign trial = {hi_q, lo_q[MSB]};
    assign tdiff = trial - {1'b0, a_q};
    assign ge    = !tdiff[WIDTH];

    always_comb begin
        sc_res = data_B;
        unique case (op_code)
            OP_ADD:  sc_res = data_B + data_A;
            OP_SUB:  sc_res = data_B - data_A;
            OP_INC:  sc_res = data_B + WIDTH'(1);
            OP_DEC:  sc_res = data_B - WIDTH'(1);
            OP_AND:  sc_res = data_B & data_A;
            OP_OR:   sc_res = data_B | data_A;
            OP_XOR:  sc_res = data_B ^ data_A;
            default: sc_res = data_B;
        endcase
    end

`ifdef SEQ_ALU_FLAGS_EN
    logic [4:0] flg_q, flg_d;
    logic       sc_c;
    logic       sc_v;

    assign flags = flg_q;

    always_comb begin
        sc_c = 1'b0;
        sc_v = 1'b0;
        unique case (op_code)
            OP_ADD: begin
                sc_c = (sc_res < data_B);
                sc_v = (data_B[MSB] == data_A[MSB])
                    && (sc_res[MSB] != data_B[MSB]);
            end
            OP_SUB: begin
                sc_c = (data_B < data_A);
                sc_v = (data_B[MSB] != data_A[MSB])
                    && (sc_res[MSB] != data_B[MSB]);
            end
            OP_INC: begin
                sc_c = &data_B;
                sc_v = !data_B[MSB] && sc_res[MSB];
            end
            OP_DEC: begin
                sc_c = ~|data_B;
                sc_v = data_B[MSB] && !sc_res[MSB];
            end
            default: begin
                sc_c = 1'b0;
                sc_v = 1'b0;
            end
        endcase
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        res_d   = res_q;
        rhi_d   = rhi_q;
`ifdef SEQ_ALU_FLAGS_EN
        flg_d   = flg_q;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
                if (accept) begin
                    if (start_mul || start_div) begin
                        state_d = start_mul ? MUL : DIV;
                        cnt_d   = CW'(WIDTH - 1);
                        a_d     = data_A;
                        hi_d    = '0;
                        lo_d    = data_B;
                    end else if (div_zero) begin
                        state_d = DONE;
                        res_d   = '1;
                        rhi_d   = data_B;
`ifdef SEQ_ALU_FLAGS_EN
                        flg_d   = 5'b10010;
`endif
                    end else begin
                        state_d = DONE;
                        res_d   = sc_res;
                        rhi_d   = '0;
`ifdef SEQ_ALU_FLAGS_EN
                        flg_d   = {1'b0, sc_v, sc_c,
                                   sc_res[MSB],
                                   sc_res == '0};
`endif
                    end
                end
            end
            MUL: begin
                hi_d  = mac[WIDTH:1];
                lo_d  = {mac[0], lo_q[MSB:1]};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    res_d   = lo_d;
                    rhi_d   = hi_d;
`ifdef SEQ_ALU_FLAGS_EN
                    flg_d   = {1'b0, hi_d != '0,
                               hi_d != '0,
                               lo_d[MSB], lo_d == '0};
`endif
                end
            end
            DIV: begin
                hi_d  = ge ? tdiff[MSB:0] : trial[MSB:0];
                lo_d  = {lo_q[WIDTH-2:0], ge};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    res_d   = lo_d;
                    rhi_d   = hi_d;
`ifdef SEQ_ALU_FLAGS_EN
                    flg_d   = {3'b000, lo_d[MSB],
                               lo_d == '0};
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            res_q   <= '0;
            rhi_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            res_q   <= res_d;
            rhi_q   <= rhi_d;
        end
    end

`ifdef SEQ_ALU_FLAGS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flg_q <= '0;
        end else begin
            flg_q <= flg_d;
        end
    end
`endif

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: randomized self-checking bench for seq_alu at WIDTH=8.
// Define SEQ_ALU_FLAGS_EN to also check the flags output.

`ifndef ADD
`define ADD  16'h0001
`define SUB  16'h0002
`define MULT 16'h0004
`define DIV  16'h0008
`define INC  16'h0010
`define DEC  16'h0020
`define AND  16'h0040
`define OR   16'h0080
`define XOR  16'h0100
`endif

module tb_seq_alu;

    localparam int W = 8;

    localparam logic [15:0] OP_ADD  = 16'(`ADD);
    localparam logic [15:0] OP_SUB  = 16'(`SUB);
    localparam logic [15:0] OP_MULT = 16'(`MULT);
    localparam logic [15:0] OP_DIV  = 16'(`DIV);
    localparam logic [15:0] OP_INC  = 16'(`INC);
    localparam logic [15:0] OP_DEC  = 16'(`DEC);
    localparam logic [15:0] OP_AND  = 16'(`AND);
    localparam logic [15:0] OP_OR   = 16'(`OR);
    localparam logic [15:0] OP_XOR  = 16'(`XOR);
    localparam logic [15:0] OP_BAD  = 16'h0003;

    typedef struct {
        logic [15:0] op;
        logic [7:0]  b;
        logic [7:0]  a;
        logic [7:0]  lo;
        logic [7:0]  hi;
        logic [4:0]  fl;
        int          lat;
    } vec_t;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] op_code   = 16'h0;
    logic [7:0]  data_A    = 8'h0;
    logic [7:0]  data_B    = 8'h0;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  result;
    logic [7:0]  result_hi;
`ifdef SEQ_ALU_FLAGS_EN
    logic [4:0]  flags;
`else
    logic [4:0]  flags;
    assign flags = 5'b0;
`endif

    int total = 0;
    int bad   = 0;

    seq_alu #(.WIDTH(W), .OP_BITS(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_code   (op_code),
        .data_A    (data_A),
        .data_B    (data_B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi)
`ifdef SEQ_ALU_FLAGS_EN
        ,
        .flags     (flags)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic on the operand values
    function automatic void model(
        input  logic [15:0] op,
        input  logic [7:0]  a,
        input  logic [7:0]  b,
        output logic [7:0]  lo,
        output logic [7:0]  hi,
        output logic [4:0]  fl,
        output int          lat
    );
        int s, ss, sa, sb;
        logic c, v, dz;
        sa = int'($signed(a));
        sb = int'($signed(b));
        s = 0; ss = 0;
        lo = b; hi = 8'h00; lat = 1;
        c = 1'b0; v = 1'b0; dz = 1'b0;
        case (op)
            OP_ADD: begin
                s = int'(b) + int'(a); lo = 8'(s);
                c = (s > 255); ss = sb + sa;
                v = (ss > 127) || (ss < -128);
            end
            OP_SUB: begin
                s = int'(b) - int'(a); lo = 8'(s);
                c = (b < a); ss = sb - sa;
                v = (ss > 127) || (ss < -128);
            end
            OP_INC: begin
                s = int'(b) + 1; lo = 8'(s);
                c = (s > 255); v = (sb + 1 > 127);
            end
            OP_DEC: begin
                s = int'(b) - 1; lo = 8'(s);
                c = (b == 8'h00); v = (sb - 1 < -128);
            end
            OP_AND: lo = b & a;
            OP_OR:  lo = b | a;
            OP_XOR: lo = b ^ a;
            OP_MULT: begin
                s = int'(b) * int'(a);
                lo = 8'(s); hi = 8'(s / 256);
                c = (s > 255); v = c; lat = 9;
            end
            OP_DIV: begin
                if (a == 8'h00) begin
                    lo = 8'hFF; hi = b; dz = 1'b1;
                end else begin
                    lo = 8'(int'(b) / int'(a));
                    hi = 8'(int'(b) % int'(a));
                    lat = 9;
                end
            end
            default: lo = b;
        endcase
        fl = {dz, v, c, lo[7], lo == 8'h00};
    endfunction

    // Issue one op from IDLE, wait (bounded) for completion, then drain it
    task automatic run_op(
        input  logic [15:0] op,
        input  logic [7:0]  a,
        input  logic [7:0]  b,
        output int          lat,
        output logic [7:0]  lo,
        output logic [7:0]  hi,
        output logic [4:0]  fl,
        output int          rdy
    );
        op_code = op; data_A = a; data_B = b;
        in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        op_code = 16'($urandom);
        data_A = 8'($urandom);
        data_B = 8'($urandom);
        lat = 1; rdy = 0;
        while (!out_valid && lat < 40) begin
            if (in_ready) rdy++;
            tick();
            lat++;
        end
        if (!out_valid) lat = -1;
        lo = result; hi = result_hi; fl = flags;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        total++;
        if (in_ready !== 1'b0) begin
            bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready);
        end
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid);
        end
        total++;
        if (result !== 8'h00 || result_hi !== 8'h00) begin
            bad++; $display("FAIL reset_result got=%h/%h want=00/00", result, result_hi);
        end
`ifdef SEQ_ALU_FLAGS_EN
        total++;
        if (flags !== 5'b0) begin
            bad++; $display("FAIL reset_flags got=%b want=00000", flags);
        end
`endif
        rst_n = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL idle_in_ready got=%b want=1", in_ready);
        end
    endtask

    task automatic test_directed();
        vec_t v [6];
        int lat, rdy;
        logic [7:0] lo, hi;
        logic [4:0] fl;
        v[0] = '{OP_ADD,  8'hF0, 8'h20, 8'h10, 8'h00, 5'b00100, 1};
        v[1] = '{OP_SUB,  8'h80, 8'h01, 8'h7F, 8'h00, 5'b01000, 1};
        v[2] = '{OP_DEC,  8'h00, 8'h5A, 8'hFF, 8'h00, 5'b00110, 1};
        v[3] = '{OP_MULT, 8'hC8, 8'h03, 8'h58, 8'h02, 5'b01100, 9};
        v[4] = '{OP_DIV,  8'h64, 8'h07, 8'h0E, 8'h02, 5'b00000, 9};
        v[5] = '{OP_DIV,  8'h64, 8'h00, 8'hFF, 8'h64, 5'b10010, 1};
        for (int i = 0; i < 6; i++) begin
            run_op(v[i].op, v[i].a, v[i].b, lat, lo, hi, fl, rdy);
            total++;
            if (lo !== v[i].lo) begin
                bad++; $display("FAIL dir%0d_result got=%h want=%h", i, lo, v[i].lo);
            end
            total++;
            if (hi !== v[i].hi) begin
                bad++; $display("FAIL dir%0d_result_hi got=%h want=%h", i, hi, v[i].hi);
            end
            total++;
            if (lat !== v[i].lat) begin
                bad++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, v[i].lat);
            end
            total++;
            if (rdy !== 0) begin
                bad++; $display("FAIL dir%0d_busy_ready got=%0d want=0", i, rdy);
            end
            total++;
            if (in_ready !== 1'b1) begin
                bad++; $display("FAIL dir%0d_ready_after got=%b want=1", i, in_ready);
            end
`ifdef SEQ_ALU_FLAGS_EN
            total++;
            if (fl !== v[i].fl) begin
                bad++; $display("FAIL dir%0d_flags got=%b want=%b", i, fl, v[i].fl);
            end
`endif
        end
    endtask

    task automatic test_random();
        logic [15:0] ops [10];
        logic [15:0] op;
        logic [7:0] a, b, lo, hi, elo, ehi;
        logic [4:0] fl, efl;
        int lat, elat, rdy;
        ops = '{OP_ADD, OP_SUB, OP_MULT, OP_DIV, OP_INC,
                OP_DEC, OP_AND, OP_OR, OP_XOR, OP_BAD};
        for (int i = 0; i < 40; i++) begin
            op = ops[$urandom_range(0, 9)];
            a = 8'($urandom);
            b = 8'($urandom);
            if ($urandom_range(0, 7) == 0) a = 8'h00;
            model(op, a, b, elo, ehi, efl, elat);
            run_op(op, a, b, lat, lo, hi, fl, rdy);
            total++;
            if (lo !== elo || hi !== ehi) begin
                bad++;
                $display("FAIL rnd%0d op=%h b=%h a=%h got=%h/%h want=%h/%h",
                         i, op, b, a, hi, lo, ehi, elo);
            end
            total++;
            if (lat !== elat) begin
                bad++; $display("FAIL rnd%0d_latency op=%h got=%0d want=%0d", i, op, lat, elat);
            end
            total++;
            if (rdy !== 0) begin
                bad++; $display("FAIL rnd%0d_busy_ready got=%0d want=0", i, rdy);
            end
`ifdef SEQ_ALU_FLAGS_EN
            total++;
            if (fl !== efl) begin
                bad++; $display("FAIL rnd%0d_flags op=%h got=%b want=%b", i, op, fl, efl);
            end
`endif
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] a, b, elo, ehi, xlo, xhi;
        logic [4:0] efl, xfl;
        int elat, xlat;
        a = 8'($urandom); b = 8'($urandom);
        model(OP_ADD, a, b, elo, ehi, efl, elat);
        op_code = OP_ADD; data_A = a; data_B = b;
        in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            total++;
            if (out_valid !== 1'b1 || result !== elo) begin
                bad++;
                $display("FAIL hold%0d valid/result got=%b/%h want=1/%h", k, out_valid, result, elo);
            end
            total++;
            if (in_ready !== 1'b0) begin
                bad++; $display("FAIL hold%0d_in_ready got=%b want=0", k, in_ready);
            end
`ifdef SEQ_ALU_FLAGS_EN
            total++;
            if (flags !== efl) begin
                bad++; $display("FAIL hold%0d_flags got=%b want=%b", k, flags, efl);
            end
`endif
            data_A = 8'($urandom);
            tick();
        end
        a = 8'($urandom); b = 8'($urandom);
        model(OP_XOR, a, b, xlo, xhi, xfl, xlat);
        op_code = OP_XOR; data_A = a; data_B = b;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL drain_in_ready got=%b want=1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || result !== xlo) begin
            bad++;
            $display("FAIL xor_no_bubble valid/result got=%b/%h want=1/%h", out_valid, result, xlo);
        end
        tick();
        total++;
        if (out_valid !== 1'b0 || result !== xlo) begin
            bad++;
            $display("FAIL drain_idle valid/result got=%b/%h want=0/%h", out_valid, result, xlo);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [15:0] sc_ops [8];
        logic [15:0] op;
        logic [7:0] a, b, elo, ehi;
        logic [4:0] efl;
        int elat, lat;
        sc_ops = '{OP_ADD, OP_SUB, OP_INC, OP_DEC,
                   OP_AND, OP_OR, OP_XOR, OP_BAD};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            op = sc_ops[$urandom_range(0, 7)];
            a = 8'($urandom); b = 8'($urandom);
            model(op, a, b, elo, ehi, efl, elat);
            op_code = op; data_A = a; data_B = b;
            in_valid = 1'b1;
            tick();
            total++;
            if (out_valid !== 1'b1 || result !== elo || result_hi !== ehi) begin
                bad++;
                $display("FAIL b2b%0d op=%h got=%b %h/%h want=1 %h/%h",
                         i, op, out_valid, result_hi, result, ehi, elo);
            end
`ifdef SEQ_ALU_FLAGS_EN
            total++;
            if (flags !== efl) begin
                bad++; $display("FAIL b2b%0d_flags got=%b want=%b", i, flags, efl);
            end
`endif
        end
        a = 8'($urandom); b = 8'($urandom);
        model(OP_MULT, a, b, elo, ehi, efl, elat);
        op_code = OP_MULT; data_A = a; data_B = b;
        tick();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL b2b_mul_start got=%b want=0", out_valid);
        end
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        total++;
        if (lat !== elat || result !== elo || result_hi !== ehi) begin
            bad++;
            $display("FAIL b2b_mul got=%0d %h/%h want=%0d %h/%h",
                     lat, result_hi, result, elat, ehi, elo);
        end
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL b2b_drain got=%b want=0", out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int seen, lat, rdy;
        logic [7:0] lo, hi;
        logic [4:0] fl;
        op_code = OP_MULT;
        data_A = 8'($urandom) | 8'h01;
        data_B = 8'($urandom) | 8'h80;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++; $display("FAIL mid_rst_in_ready got=%b want=0", in_ready);
        end
        tick();
        rst_n = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || result !== 8'h00 || result_hi !== 8'h00) begin
            bad++;
            $display("FAIL mid_rst_out got=%b %h/%h want=0 00/00", out_valid, result_hi, result);
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL mid_rst_ready got=%b want=1", in_ready);
        end
`ifdef SEQ_ALU_FLAGS_EN
        total++;
        if (flags !== 5'b0) begin
            bad++; $display("FAIL mid_rst_flags got=%b want=00000", flags);
        end
`endif
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            if (out_valid) seen++;
            tick();
        end
        total++;
        if (seen !== 0) begin
            bad++; $display("FAIL mid_rst_stray got=%0d want=0", seen);
        end
        run_op(OP_ADD, 8'h01, 8'h01, lat, lo, hi, fl, rdy);
        total++;
        if (lo !== 8'h02 || lat !== 1) begin
            bad++; $display("FAIL post_rst_add got=%h lat=%0d want=02 lat=1", lo, lat);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, handshaked successor to the combinational datapath ALU.
- Computes the same operation set: ADD, SUB, MULT, DIV, INC, DEC, AND, OR, XOR, plus pass-through.
- Single-cycle ops are registered. MULT and DIV are iterative, so no wide combinational multiplier or divider is needed.
- Also returns the upper product half, the division remainder and optional status flags. Sits between the register-file read stage and writeback.

Parameters:
- WIDTH, 16, operand/result width in bits; must be >= 4.
- OP_BITS, 16, opcode width; opcode values are the `ADD ... `XOR macros from defines.sv.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset: synchronous, active-low.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request this cycle.
- op_code  in  OP_BITS  operation select.
- data_A  in  WIDTH  right operand.
- data_B  in  WIDTH  left operand; result = B op A.
- out_valid  out  1  result registers hold a completed operation.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  low result; quotient for DIV.
- result_hi  out  WIDTH  upper product half for MULT; remainder for DIV; 0 otherwise.
- flags  out  5  {DZ,V,C,N,Z}; present only with SEQ_ALU_FLAGS_EN.

Behaviour:
- Reset:
  - Clocked while rst_n=0: state=IDLE; out_valid, result, result_hi, flags and iteration counter all 0.
  - in_ready=0 while rst_n=0.
  - Reset mid-operation abandons the operation; no output is produced for it.
- States:
  - IDLE: in_ready=1.
  - MUL / DIV: busy, in_ready=0.
  - DONE: out_valid=1; in_ready=out_ready.
- Accept: transfer happens when in_valid && in_ready. Operands and opcode are captured; the inputs may then change.
- Single-cycle ops (ADD, SUB, INC, DEC, AND, OR, XOR, unknown opcode):
  - Result is registered on the accept edge; out_valid=1 the next cycle (latency 1).
  - INC/DEC act on B.
  - An unknown opcode passes B through.
  - All arithmetic wraps modulo 2^WIDTH.
- MULT:
  - Unsigned radix-2 shift-add, one step per cycle, WIDTH steps.
  - out_valid rises WIDTH+1 cycles after accept.
  - {result_hi,result} = full 2*WIDTH-bit product.
- DIV:
  - Unsigned restoring division, WIDTH steps; same latency as MULT.
  - result = B/A, result_hi = B%A.
- Divide by zero (A=0):
  - No iteration; latency 1.
  - result = all ones, result_hi = B, DZ=1.
- DONE:
  - Outputs stay stable while out_valid && !out_ready.
  - On out_ready=1 without a new accept: go to IDLE, out_valid=0 next cycle; result, result_hi and flags keep their last values.
  - Accept in the same cycle as the drain (back-to-back): the new op starts immediately. A single-cycle op keeps out_valid=1 continuously with the new values.
- Simultaneous in_valid in MUL/DIV: ignored (in_ready=0); the requester must hold the request.
- No combinational path from in_valid to out_valid. in_ready depends combinationally only on state and out_ready.

Optional Feature:
- Macro: SEQ_ALU_FLAGS_EN.
- Defined: flags port exists and registers with result.
  - Z = (result==0); N = result[WIDTH-1].
  - C = carry out for ADD/INC; borrow (B<A) for SUB; borrow (B==0) for DEC; (result_hi!=0) for MULT; 0 otherwise.
  - V = signed overflow for ADD/SUB/INC/DEC; C for MULT; 0 otherwise.
  - DZ = divide by zero; 0 otherwise.
  - All flags reset to 0.
- Undefined: flags port and its logic are absent; all other behaviour is identical.

Test Plan (WIDTH=8):
- ADD, B=F0, A=20, out_ready=1 -> one cycle after accept: result=10, result_hi=00, flags C=1, Z=0, V=0; in_ready back to 1.
- SUB, B=80, A=01 -> result=7F, V=1, C=0, N=0; DEC with B=00 -> result=FF, C=1, N=1.
- MULT, B=C8, A=03 -> out_valid exactly 9 cycles after accept: result=58, result_hi=02, C=V=1; in_ready=0 during cycles 1..8.
- DIV, B=64, A=07 -> after 9 cycles: result=0E, result_hi=02. DIV B=64, A=00 -> after 1 cycle: result=FF, result_hi=64, DZ=1.
- Backpressure: ADD completes with out_ready=0 for 5 cycles -> result, flags and out_valid held, in_ready=0. Raise out_ready together with a new XOR request -> no bubble in out_valid, XOR result appears the next cycle.
- Reset: rst_n=0 for one clock at MULT step 4 -> next cycle out_valid=0, result=00, in_ready=1; a fresh ADD 01+01 then yields result=02.
